// File: rtl/cons_pkg.sv
// cons_pkg: shared state encoding and run-count transition rule for cons_detector
package cons_pkg;
  localparam int N_ONES_DEF = 3;
  localparam int CNT_W = $clog2(N_ONES_DEF + 1);
  typedef enum logic [CNT_W-1:0] {S0, S1, S2, S3} state_t;
  function automatic int next_cnt(input int c, input logic b, input int n, input logic ovl);
    return (!b || c > n) ? 0 : (c == n) ? (ovl ? n : 1) : c + 1;
  endfunction
endpackage

// File: rtl/cons_detector.sv
// cons_detector: Moore detector flagging N_ONES consecutive '1' samples on i
module cons_detector
  import cons_pkg::*;
#(
  parameter int N_ONES  = N_ONES_DEF,
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i,
  output logic y
);
  localparam int W = $clog2(N_ONES + 1);
  localparam logic [W-1:0] DET = W'(N_ONES);
  logic [W-1:0] cnt, nxt;
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else cnt <= nxt;
  // out-of-range counts fall back to zero through next_cnt
  always_comb begin
    nxt = W'(next_cnt(int'(cnt), i, N_ONES, OVERLAP));
    y = (cnt == DET);
  end
endmodule

// File: tb/tb_cons_detector.sv
// tb_cons_detector: directed and random checks of both overlap modes against a run-length model
module tb_cons_detector;
  localparam int N = 3;
  logic clk = 1'b0, rst = 1'b0, i = 1'b0;
  logic y_o, y_n;
  int run = 0;
  int errors = 0, checks = 0;
  cons_detector #(.N_ONES(N), .OVERLAP(1'b1)) dut_o (.clk(clk), .rst(rst), .i(i), .y(y_o));
  cons_detector #(.N_ONES(N), .OVERLAP(1'b0)) dut_n (.clk(clk), .rst(rst), .i(i), .y(y_n));
  always #5 clk = ~clk;
  function automatic logic exp_o();
    return run >= N;
  endfunction
  function automatic logic exp_n();
    return run > 0 && run % N == 0;
  endfunction
  task automatic step(input logic b, input logic r);
    i = b;
    rst = r;
    @(posedge clk);
    #1;
    run = r ? 0 : b ? run + 1 : 0;
  endtask
  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1);
      checks += 2;
      if (y_o !== 1'b0) begin errors++; $display("FAIL reset[%0d] y_ovl=%b expected=0", k, y_o); end
      if (y_n !== 1'b0) begin errors++; $display("FAIL reset[%0d] y_novl=%b expected=0", k, y_n); end
    end
    step(1'b0, 1'b0);
    checks++;
    if (y_o !== 1'b0) begin errors++; $display("FAIL reset_release y_ovl=%b expected=0", y_o); end
  endtask
  task automatic test_basic();
    logic [3:0] stim = 4'b1110;
    logic [3:0] want = 4'b0010;
    for (int k = 0; k < 4; k++) begin
      step(stim[3-k], 1'b0);
      checks += 2;
      if (y_o !== want[3-k]) begin errors++; $display("FAIL basic[%0d] y_ovl=%b expected=%b", k, y_o, want[3-k]); end
      if (y_n !== want[3-k]) begin errors++; $display("FAIL basic[%0d] y_novl=%b expected=%b", k, y_n, want[3-k]); end
    end
  endtask
  task automatic test_broken();
    logic [5:0] stim = 6'b110110;
    for (int k = 0; k < 6; k++) begin
      step(stim[5-k], 1'b0);
      checks += 2;
      if (y_o !== 1'b0) begin errors++; $display("FAIL broken[%0d] y_ovl=%b expected=0", k, y_o); end
      if (y_n !== 1'b0) begin errors++; $display("FAIL broken[%0d] y_novl=%b expected=0", k, y_n); end
    end
  endtask
  task automatic test_overlap();
    logic [6:0] want_o = 7'b0011111;
    logic [6:0] want_n = 7'b0010010;
    step(1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 1'b0);
      checks += 2;
      if (y_o !== want_o[6-k]) begin errors++; $display("FAIL overlap[%0d] y_ovl=%b expected=%b", k, y_o, want_o[6-k]); end
      if (y_n !== want_n[6-k]) begin errors++; $display("FAIL overlap[%0d] y_novl=%b expected=%b", k, y_n, want_n[6-k]); end
    end
    step(1'b0, 1'b0);
    checks++;
    if (y_o !== 1'b0) begin errors++; $display("FAIL overlap_fall y_ovl=%b expected=0", y_o); end
  endtask
  task automatic test_frames();
    logic [15:0] stim = 16'b1110111011101111;
    int highs = 0;
    for (int k = 0; k < 16; k++) begin
      step(stim[15-k], 1'b0);
      highs += int'(y_o);
      checks += 2;
      if (y_o !== exp_o()) begin errors++; $display("FAIL frames[%0d] y_ovl=%b expected=%b", k, y_o, exp_o()); end
      if (y_n !== exp_n()) begin errors++; $display("FAIL frames[%0d] y_novl=%b expected=%b", k, y_n, exp_n()); end
    end
    checks++;
    if (highs != 5) begin errors++; $display("FAIL frames_pulses count=%0d expected=5", highs); end
  endtask
  task automatic test_reset_mid();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    checks++;
    if (y_o !== 1'b0) begin errors++; $display("FAIL reset_mid_rst y_ovl=%b expected=0", y_o); end
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b0);
      checks += 2;
      if (y_o !== (k == 2)) begin errors++; $display("FAIL reset_mid[%0d] y_ovl=%b expected=%b", k, y_o, k == 2); end
      if (y_n !== (k == 2)) begin errors++; $display("FAIL reset_mid[%0d] y_novl=%b expected=%b", k, y_n, k == 2); end
    end
  endtask
  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 9) < 7), ($urandom_range(0, 49) == 0));
      checks += 2;
      if (y_o !== exp_o()) begin errors++; $display("FAIL random[%0d] y_ovl=%b expected=%b", k, y_o, exp_o()); end
      if (y_n !== exp_n()) begin errors++; $display("FAIL random[%0d] y_novl=%b expected=%b", k, y_n, exp_n()); end
    end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_broken();
    test_overlap();
    test_frames();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
